// File: rtl/regfile_mp.sv
// Multi-ported register file with a small pending-write scoreboard.
// After reset an INIT sweep zeroes every register one per cycle before RUN is entered.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*XLEN-1:0]  wr_data,
    input  logic                 alloc_en,
    input  logic [AW-1:0]        alloc_addr,
    output logic                 ready
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            state_reg, state_next;
    logic [AW-1:0]     clr_cnt;
    logic [XLEN-1:0]   regs [NREGS];
    logic [NREGS-1:0]  busy_reg, busy_next;
    logic              run;
    logic [NWR-1:0]    wr_ok;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_INIT;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (state_reg == S_INIT && clr_cnt == AW'(NREGS - 1))
            state_next = S_RUN;
    end

    // run also folds in rst so a reset edge discards every pending write and alloc
    always_comb begin
        ready = 1'b0;
        run   = 1'b0;
        if (state_reg == S_RUN) begin
            ready = 1'b1;
            run   = ~rst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                    clr_cnt <= '0;
        else if (state_reg == S_INIT) clr_cnt <= clr_cnt + 1'b1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NWR; gi++) begin : g_wr
            assign wr_ok[gi] = run && wr_en[gi] &&
                               !(ZERO_REG && wr_addr[gi*AW +: AW] == '0);
        end
    endgenerate

    // Storage is never reset; only the INIT sweep clears it. Later ports override earlier ones.
    always_ff @(posedge clk) begin
        if (!rst && state_reg == S_INIT) begin
            regs[clr_cnt] <= '0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (wr_ok[k])
                    regs[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
            end
        end
    end

    // Writes clear busy first so a same-cycle alloc to that register keeps it pending
    always_comb begin
        busy_next = busy_reg;
        for (int k = 0; k < NWR; k++) begin
            if (wr_ok[k])
                busy_next[wr_addr[k*AW +: AW]] = 1'b0;
        end
        if (run && alloc_en)
            busy_next[alloc_addr] = 1'b1;
        if (ZERO_REG)
            busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_reg <= '0;
        else     busy_reg <= busy_next;
    end

    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   ra;
            logic [XLEN-1:0] rv;

            assign ra = rd_addr[gi*AW +: AW];

            always_comb begin
                rv = regs[ra];
                if (BYPASS) begin
                    for (int k = 0; k < NWR; k++) begin
                        if (wr_ok[k] && wr_addr[k*AW +: AW] == ra)
                            rv = wr_data[k*XLEN +: XLEN];
                    end
                end
                if (!ready || (ZERO_REG && ra == '0))
                    rv = '0;
            end

            assign rd_data[gi*XLEN +: XLEN] = rv;
            assign rd_busy[gi]              = ready & busy_reg[ra];
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// compared against an array-based model of the register file and scoreboard.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        alloc_en;
    logic [4:0]  alloc_addr;
    logic        ready;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          m_ready = 0;
    int          m_cnt = 0;

    regfile_mp dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    task automatic idle();
        wr_en = 2'b00; wr_addr = '0; wr_data = '0;
        alloc_en = 1'b0; alloc_addr = '0;
    endtask

    // Advance the model by one edge using the inputs now applied, then clock the DUT.
    task automatic cyc();
        if (rst) begin
            m_ready = 0;
            m_cnt   = 0;
            for (int i = 0; i < 32; i++) m_busy[i] = 0;
        end else if (!m_ready) begin
            m_regs[m_cnt] = 32'h0;
            m_cnt++;
            if (m_cnt == 32) m_ready = 1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                int a;
                a = int'(wr_addr[k*5 +: 5]);
                if (wr_en[k] && a != 0) begin
                    m_regs[a] = wr_data[k*32 +: 32];
                    m_busy[a] = 0;
                end
            end
            if (alloc_en && alloc_addr != 5'd0) m_busy[alloc_addr] = 1;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_rd(int a);
        logic [31:0] v;
        if (!m_ready || a == 0) return 32'h0;
        v = m_regs[a];
        for (int k = 0; k < 2; k++)
            if (wr_en[k] && int'(wr_addr[k*5 +: 5]) == a) v = wr_data[k*32 +: 32];
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1; idle(); rd_addr = '0;
        repeat (3) cyc();
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %b exp 0", ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd_addr = 10'($urandom);
            #2;
            checks++;
            if (ready !== 1'b0 || rd_data !== 64'h0 || rd_busy !== 2'b00) begin
                errors++;
                $display("FAIL init_cycle%0d got ready=%b data=%h busy=%b exp 0/0/0",
                         i, ready, rd_data, rd_busy);
            end
            cyc();
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_init got %b exp 1", ready);
        end
        for (int a = 0; a < 32; a += 2) begin
            rd_addr = {5'(a + 1), 5'(a)};
            #1;
            checks++;
            if (rd_data !== 64'h0) begin
                errors++; $display("FAIL init_zero x%0d/x%0d got %h exp 0", a, a + 1, rd_data);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_collision();
        idle();
        wr_en = 2'b11; wr_addr = {5'd5, 5'd5};
        wr_data = {32'h5555FFFF, 32'hAAAA0000};
        rd_addr = {5'd0, 5'd5};
        #2;
        checks++;
        if (rd_data[31:0] !== 32'h5555FFFF) begin
            errors++; $display("FAIL collision_bypass got %h exp 5555ffff", rd_data[31:0]);
        end
        cyc();
        idle();
        #2;
        checks++;
        if (rd_data[31:0] !== 32'h5555FFFF) begin
            errors++; $display("FAIL collision_x5 got %h exp 5555ffff", rd_data[31:0]);
        end
        $display("test_collision x5=%h", rd_data[31:0]);
    endtask

    task automatic test_bypass();
        idle();
        wr_en = 2'b10; wr_addr = {5'd7, 5'd0}; wr_data = {32'h12345678, 32'h0};
        rd_addr = {5'd5, 5'd7};
        #2;
        checks++;
        if (rd_data[31:0] !== 32'h12345678) begin
            errors++; $display("FAIL bypass_same_cycle got %h exp 12345678", rd_data[31:0]);
        end
        cyc();
        idle();
        #2;
        checks++;
        if (rd_data[31:0] !== 32'h12345678) begin
            errors++; $display("FAIL bypass_stored got %h exp 12345678", rd_data[31:0]);
        end
        $display("test_bypass x7=%h", rd_data[31:0]);
    endtask

    task automatic test_zero_reg();
        idle();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'hFFFFFFFF};
        alloc_en = 1'b1; alloc_addr = 5'd0;
        rd_addr = {5'd0, 5'd0};
        #2;
        checks++;
        if (rd_data !== 64'h0) begin
            errors++; $display("FAIL zero_same_cycle got %h exp 0", rd_data);
        end
        cyc();
        idle();
        #2;
        checks++;
        if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
            errors++; $display("FAIL zero_next got data=%h busy=%b exp 0/00", rd_data, rd_busy);
        end
        $display("test_zero_reg x0=%h", rd_data[31:0]);
    endtask

    task automatic test_scoreboard();
        idle();
        alloc_en = 1'b1; alloc_addr = 5'd9; rd_addr = {5'd0, 5'd9};
        #2;
        checks++;
        if (rd_busy[0] !== 1'b0) begin
            errors++; $display("FAIL sb_before_alloc got %b exp 0", rd_busy[0]);
        end
        cyc();
        idle();
        #2;
        checks++;
        if (rd_busy[0] !== 1'b1) begin
            errors++; $display("FAIL sb_alloc got %b exp 1", rd_busy[0]);
        end
        alloc_en = 1'b1; alloc_addr = 5'd9;
        wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'hCAFE0009};
        cyc();
        idle();
        #2;
        checks++;
        if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'hCAFE0009) begin
            errors++;
            $display("FAIL sb_alloc_wins got busy=%b data=%h exp 1/cafe0009", rd_busy[0], rd_data[31:0]);
        end
        wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h0BADF00D, 32'h0};
        #2;
        checks++;
        if (rd_busy[0] !== 1'b1) begin
            errors++; $display("FAIL sb_no_bypass got %b exp 1", rd_busy[0]);
        end
        cyc();
        idle();
        #2;
        checks++;
        if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL sb_write_clears got busy=%b data=%h exp 0/0badf00d", rd_busy[0], rd_data[31:0]);
        end
        $display("test_scoreboard done");
    endtask

    task automatic test_reset_mid_run();
        idle();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h1};
        cyc();
        idle();
        rd_addr = {5'd0, 5'd3};
        #2;
        checks++;
        if (rd_data[31:0] !== 32'h1) begin
            errors++; $display("FAIL mid_x3_written got %h exp 1", rd_data[31:0]);
        end
        rst = 1'b1;
        wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'hDEAD0004};
        alloc_en = 1'b1; alloc_addr = 5'd5;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            wr_en = 2'($urandom); wr_addr = 10'($urandom);
            wr_data = {$urandom, $urandom};
            alloc_en = 1'($urandom); alloc_addr = 5'($urandom);
            rd_addr = wr_addr;
            #2;
            checks++;
            if (ready !== 1'b0 || rd_data !== 64'h0 || rd_busy !== 2'b00) begin
                errors++;
                $display("FAIL mid_init%0d got ready=%b data=%h busy=%b exp 0/0/0",
                         i, ready, rd_data, rd_busy);
            end
            cyc();
        end
        idle();
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL mid_ready got %b exp 1", ready);
        end
        for (int a = 0; a < 32; a += 2) begin
            rd_addr = {5'(a + 1), 5'(a)};
            #1;
            checks++;
            if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
                errors++;
                $display("FAIL mid_cleared x%0d/x%0d got data=%h busy=%b exp 0/00",
                         a, a + 1, rd_data, rd_busy);
            end
        end
        $display("test_reset_mid_run done");
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            logic [31:0] e0, e1;
            logic [1:0]  eb;
            wr_en = 2'($urandom);
            for (int k = 0; k < 2; k++) begin
                wr_addr[k*5 +: 5] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3))
                                                                : 5'($urandom);
                wr_data[k*32 +: 32] = $urandom;
            end
            alloc_en   = 1'($urandom);
            alloc_addr = 5'($urandom_range(0, 7));
            rd_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 3))};
            #2;
            e0 = exp_rd(int'(rd_addr[4:0]));
            e1 = exp_rd(int'(rd_addr[9:5]));
            eb = {m_busy[rd_addr[9:5]], m_busy[rd_addr[4:0]]};
            checks++;
            if (rd_data[31:0] !== e0) begin
                errors++; $display("FAIL rnd%0d_rd0 got %h exp %h", n, rd_data[31:0], e0);
            end
            checks++;
            if (rd_data[63:32] !== e1) begin
                errors++; $display("FAIL rnd%0d_rd1 got %h exp %h", n, rd_data[63:32], e1);
            end
            checks++;
            if (rd_busy !== eb) begin
                errors++; $display("FAIL rnd%0d_busy got %b exp %b", n, rd_busy, eb);
            end
            $display("rnd %0d we=%b wa=%h al=%b/%0d ra=%h rd=%h busy=%b",
                     n, wr_en, wr_addr, alloc_en, alloc_addr, rd_addr, rd_data, rd_busy);
            cyc();
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_busy[i] = 0;
        end
        test_reset();
        test_collision();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_random();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
